// File: rtl/debug_pkg.sv
// Shared types and default widths for the debug input conditioner and stall generator.
package debug_pkg;

    typedef enum logic [1:0] {
        DBG_RUN   = 2'd0,
        DBG_STEP  = 2'd1,
        DBG_BURST = 2'd2,
        DBG_DIV   = 2'd3
    } dbg_mode_t;

    localparam int DEB_W_DEF  = 14;
    localparam int STEP_W_DEF = 8;

endpackage

// File: rtl/input_debouncer.sv
// One conditioned board input: 2-FF synchroniser, stability counter, debounced level
// and registered edge pulses that trail the debounced level by one cycle.
module input_debouncer
    import debug_pkg::*;
#(
    parameter int   DEB_W   = DEB_W_DEF,
    parameter logic RST_VAL = 1'b1
) (
    input  logic CLK_CPU,
    input  logic resetn,
    input  logic raw_in,
    output logic deb_out,
    output logic rise_evt,
    output logic fall_evt
);

    localparam logic [DEB_W-1:0] DEB_MAX = '1;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q, prev_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic             deb_q, deb_d;
    logic             deb_dly_q, deb_dly_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        if (sync2_q != prev_q) begin
            cnt_d = DEB_MAX;
        end else if (cnt_q == '0) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
        // prev_q rather than sync2_q: a change arriving while the counter idles at 0
        // must not slip through before it has been timed.
        deb_d     = (cnt_q == '0) ? prev_q : deb_q;
        deb_dly_d = deb_q;
        rise_d    = deb_q & ~deb_dly_q;
        fall_d    = ~deb_q & deb_dly_q;
    end

    always_ff @(posedge CLK_CPU) begin
        if (!resetn) begin
            sync1_q   <= RST_VAL;
            sync2_q   <= RST_VAL;
            prev_q    <= RST_VAL;
            cnt_q     <= DEB_MAX;
            deb_q     <= RST_VAL;
            deb_dly_q <= RST_VAL;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            deb_q     <= deb_d;
            deb_dly_q <= deb_dly_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
        end
    end

    assign deb_out  = deb_q;
    assign rise_evt = rise_q;
    assign fall_evt = fall_q;

endmodule

// File: rtl/debug_step_ctrl.sv
// Board input conditioning plus CPU debug-stall generation (run / step / burst / divided run).
//   mode      | meaning
//   DBG_RUN   | CPU free-runs, stall_debug held 0
//   DBG_STEP  | stalled; one release cycle after each step press
//   DBG_BURST | stalled; step press releases max(burst_len,1) cycles, busy while releasing
//   DBG_DIV   | one release cycle every div_max+1 cycles
module debug_step_ctrl
    import debug_pkg::*;
#(
    parameter int              N_CH    = 9,
    parameter int              DEB_W   = DEB_W_DEF,
    parameter int              STEP_CH = 8,
    parameter int              STEP_W  = STEP_W_DEF,
    parameter int              DIV_W   = 10,
    parameter logic [N_CH-1:0] RST_VAL = {N_CH{1'b1}}
) (
    input  logic              CLK_CPU,
    input  logic              resetn,
    input  logic [N_CH-1:0]   raw_in,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] burst_len,
    input  logic [DIV_W-1:0]  div_max,
    output logic [N_CH-1:0]   deb_out,
    output logic [N_CH-1:0]   rise_evt,
    output logic [N_CH-1:0]   fall_evt,
    output logic              stall_debug,
    output logic              busy
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        input_debouncer #(
            .DEB_W   (DEB_W),
            .RST_VAL (RST_VAL[i])
        ) u_deb (
            .CLK_CPU  (CLK_CPU),
            .resetn   (resetn),
            .raw_in   (raw_in[i]),
            .deb_out  (deb_out[i]),
            .rise_evt (rise_evt[i]),
            .fall_evt (fall_evt[i])
        );
    end

    dbg_mode_t         mode_in;
    dbg_mode_t         mode_q, mode_d;
    logic              stall_q, stall_d;
    logic              busy_q, busy_d;
    logic [STEP_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic              mode_chg;
    logic              step_press;

    assign mode_in  = dbg_mode_t'(mode);
    assign mode_chg = (mode_in != mode_q);
    // A press coinciding with a mode change is dropped.
    assign step_press = fall_evt[STEP_CH] & ~mode_chg;

    always_comb begin
        mode_d      = mode_in;
        stall_d     = 1'b1;
        busy_d      = 1'b0;
        burst_cnt_d = '0;
        div_cnt_d   = '0;
        case (mode_in)
            DBG_RUN: begin
                stall_d = 1'b0;
            end
            DBG_STEP: begin
                stall_d = ~step_press;
            end
            DBG_BURST: begin
                // burst_cnt holds the release cycles remaining after the current one.
                if (mode_chg) begin
                    stall_d = 1'b1;
                end else if (busy_q) begin
                    if (burst_cnt_q != '0) begin
                        busy_d      = 1'b1;
                        stall_d     = 1'b0;
                        burst_cnt_d = burst_cnt_q - 1'b1;
                    end
                end else if (step_press) begin
                    busy_d      = 1'b1;
                    stall_d     = 1'b0;
                    burst_cnt_d = (burst_len == '0) ? '0 : burst_len - 1'b1;
                end
            end
            DBG_DIV: begin
                if (!mode_chg && (div_cnt_q < div_max)) begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
                stall_d = (div_cnt_d != div_max);
            end
            default: begin
                stall_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK_CPU) begin
        if (!resetn) begin
            mode_q      <= DBG_RUN;
            stall_q     <= 1'b1;
            busy_q      <= 1'b0;
            burst_cnt_q <= '0;
            div_cnt_q   <= '0;
        end else begin
            mode_q      <= mode_d;
            stall_q     <= stall_d;
            busy_q      <= busy_d;
            burst_cnt_q <= burst_cnt_d;
            div_cnt_q   <= div_cnt_d;
        end
    end

    assign stall_debug = stall_q;
    assign busy        = busy_q;

endmodule
